logic32_req_arbiter: RTL



---
 rtl/logic32_req_arbiter_if.sv | 30 +++
 rtl/logic32_req_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic32_req_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : logic32_req_arbiter_if                                        |
// | Brief    : Request/response bundle between four requesters, the shared   |
// |            32-bit logic unit and its single response consumer.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface logic32_req_arbiter_if;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [7:0]   req_op;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         rsp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero
    );
endinterface
`default_nettype wire

// File: rtl/logic32_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : logic32_req_arbiter                                           |
// | Brief    : Four requesters share one 32-bit AND/OR/NOR/INV unit; result  |
// |            lands in a single registered response slot with ID and zero.  |
// |            Define LOGIC32_ARB_RR_EN for round-robin arbitration,         |
// |            otherwise fixed priority (requester 0 highest).               |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module logic32_req_arbiter (
    input  wire logic            clk,
    input  wire logic            rst,
    logic32_req_arbiter_if.slave bus
);
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOR = 2'b10;
    localparam logic [1:0] OP_INV = 2'b11;

    logic                w_found;
    logic [ID_W-1:0]     w_grant_idx;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_slot_free;
    logic                w_req_xfer;
    logic                w_rsp_xfer;

    logic [DATA_W-1:0]   w_opa;
    logic [DATA_W-1:0]   w_opb;
    logic [1:0]          w_op;
    logic [DATA_W-1:0]   w_and;
    logic [DATA_W-1:0]   w_or;
    logic [DATA_W-1:0]   w_nor;
    logic [DATA_W-1:0]   w_inv;
    logic [DATA_W-1:0]   w_result;
    logic                w_zero;

    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
    logic [ID_W-1:0]     rsp_id_q,    rsp_id_d;
    logic                rsp_zero_q,  rsp_zero_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef LOGIC32_ARB_RR_EN
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] w_cand;

    // Search starts at the pointer and wraps naturally through the 2-bit add.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = ptr_q + ID_W'(k);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (w_req_xfer) begin
            ptr_d = w_grant_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        w_found     = |bus.req_valid;
        w_grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                w_grant_idx = ID_W'(k);
            end
        end
    end
`endif

    assign w_grant     = w_found ? (4'b0001 << w_grant_idx) : 4'b0000;
    assign w_slot_free = ~rsp_valid_q | bus.rsp_ready;

    // Gated by rst so nothing is acknowledged while the slot is being cleared.
    assign bus.req_ready = rst ? 4'b0000 : (w_grant & {NUM_REQ{w_slot_free}});
    assign w_req_xfer    = |bus.req_ready;
    assign w_rsp_xfer    = rsp_valid_q & bus.rsp_ready;

    // ------------------------------------------------------------------
    // Datapath: operand select, primitives, result select
    // ------------------------------------------------------------------
    assign w_opa = bus.req_a[{w_grant_idx, 5'b0} +: DATA_W];
    assign w_opb = bus.req_b[{w_grant_idx, 5'b0} +: DATA_W];
    assign w_op  = bus.req_op[{w_grant_idx, 1'b0} +: 2];

    AND32_2x1 u_and (.a_i(w_opa), .b_i(w_opb), .y_o(w_and));
    OR32_2x1  u_or  (.a_i(w_opa), .b_i(w_opb), .y_o(w_or));
    NOR32_2x1 u_nor (.a_i(w_opa), .b_i(w_opb), .y_o(w_nor));
    INV32_1x1 u_inv (.a_i(w_opa), .y_o(w_inv));

    always_comb begin
        w_result = w_and;
        case (w_op)
            OP_AND:  w_result = w_and;
            OP_OR:   w_result = w_or;
            OP_NOR:  w_result = w_nor;
            OP_INV:  w_result = w_inv;
            default: w_result = w_and;
        endcase
    end

    // Zero detect: fold halves together with the OR primitive down to two
    // bits, then a single NOR2 gives the flag.
    logic [DATA_W-1:0] w_fold [5];
    logic              w_unused_fold;

    assign w_fold[0] = w_result;

    for (genvar s = 0; s < 4; s++) begin : g_zero_fold
        localparam int                HALF    = 16 >> s;
        localparam logic [DATA_W-1:0] LO_MASK = DATA_W'((64'd1 << HALF) - 64'd1);
        OR32_2x1 u_fold (
            .a_i (w_fold[s] >> HALF),
            .b_i (w_fold[s] & LO_MASK),
            .y_o (w_fold[s+1])
        );
    end

    NOR2x1 u_zero (.a_i(w_fold[4][1]), .b_i(w_fold[4][0]), .y_o(w_zero));

    assign w_unused_fold = |w_fold[4][DATA_W-1:2];

    // ------------------------------------------------------------------
    // Response slot
    // ------------------------------------------------------------------
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_zero_d  = rsp_zero_q;
        if (w_req_xfer) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = w_result;
            rsp_id_d    = w_grant_idx;
            rsp_zero_d  = w_zero;
        end else if (w_rsp_xfer) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_zero_q  <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_zero  = rsp_zero_q;

endmodule

// Gate-level logic primitives used by the datapath above.
module AND32_2x1 (
    input  wire logic [31:0] a_i,
    input  wire logic [31:0] b_i,
    output logic      [31:0] y_o
);
    assign y_o = a_i & b_i;
endmodule

module OR32_2x1 (
    input  wire logic [31:0] a_i,
    input  wire logic [31:0] b_i,
    output logic      [31:0] y_o
);
    assign y_o = a_i | b_i;
endmodule

module NOR32_2x1 (
    input  wire logic [31:0] a_i,
    input  wire logic [31:0] b_i,
    output logic      [31:0] y_o
);
    assign y_o = ~(a_i | b_i);
endmodule

module INV32_1x1 (
    input  wire logic [31:0] a_i,
    output logic      [31:0] y_o
);
    assign y_o = ~a_i;
endmodule

module NOR2x1 (
    input  wire logic a_i,
    input  wire logic b_i,
    output logic      y_o
);
    assign y_o = ~(a_i | b_i);
endmodule
`default_nettype wire
